// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// alu_seq_ctrl : multi-cycle fetch/exec/mem/wb sequencer for a 9-bit ISA
// Revision     : 1.0
// ============================================================================

package alu_seq_pkg;
    localparam logic [3:0] kLSL  = 4'h0;
    localparam logic [3:0] kLSR  = 4'h1;
    localparam logic [3:0] kADD  = 4'h2;
    localparam logic [3:0] kAND  = 4'h3;
    localparam logic [3:0] kORR  = 4'h4;
    localparam logic [3:0] kEOR  = 4'h5;
    localparam logic [3:0] kTAKE = 4'h6;
    localparam logic [3:0] kMOVE = 4'h7;
    localparam logic [3:0] kLDR  = 4'h8;
    localparam logic [3:0] kSTR  = 4'h9;
    localparam logic [3:0] kCMP  = 4'hA;
    localparam logic [8:0] HALT_INSTR = 9'h1FF;
endpackage

module alu_seq_ctrl
    import alu_seq_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  instr,
    input  logic        to_jump,
    input  logic [7:0]  jump_target,
    output logic [7:0]  pc,
    output logic [8:0]  ir,
    output logic [3:0]  op,
    output logic [3:0]  reg_addr,
    output logic [3:0]  lut_idx,
    output logic        acc_we,
    output logic        rf_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic [15:0] instr_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [8:0]  ir_q, ir_d;
    logic [15:0] cnt_q, cnt_d;

    logic w_is_ldr, w_is_str, w_is_cmp, w_is_halt, w_acc_op, w_rf_op;
    logic w_idle_like, w_launch, w_retire;

    assign w_is_ldr  = ir_q[8] && (ir_q[7:4] == kLDR);
    assign w_is_str  = ir_q[8] && (ir_q[7:4] == kSTR);
    assign w_is_cmp  = ir_q[8] && (ir_q[7:4] == kCMP);
    assign w_is_halt = (ir_q == HALT_INSTR);
    // Immediates (ir[8]=0) always target the accumulator regardless of op bits.
    assign w_acc_op  = !ir_q[8] ||
                       (ir_q[7:4] inside {kLSL, kLSR, kADD, kAND, kORR, kEOR, kTAKE, kLDR});
    assign w_rf_op   = ir_q[8] && (ir_q[7:4] == kMOVE);

    assign w_idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign w_launch    = w_idle_like && start;
    assign w_retire    = (state_q == S_WB) || ((state_q == S_MEM) && w_is_str);

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_FETCH;
            S_FETCH:        state_d = S_EXEC;
            S_EXEC: begin
                if (w_is_halt)                  state_d = S_DONE;
                else if (w_is_ldr || w_is_str)  state_d = S_MEM;
                else                            state_d = S_WB;
            end
            S_MEM:          state_d = w_is_str ? S_FETCH : S_WB;
            S_WB:           state_d = S_FETCH;
            default:        state_d = S_IDLE;
        endcase
    end

    // Outputs; enables are gated by reset so a write in the reset cycle never lands.
    always_comb begin
        acc_we = 1'b0;
        rf_we  = 1'b0;
        mem_re = 1'b0;
        mem_we = 1'b0;
        busy   = !w_idle_like;
        done   = (state_q == S_DONE);
        if (!reset) begin
            case (state_q)
                S_MEM: begin
                    mem_re = w_is_ldr;
                    mem_we = w_is_str;
                end
                S_WB: begin
                    acc_we = w_acc_op;
                    rf_we  = w_rf_op;
                end
                default: ;
            endcase
        end
    end

    // Datapath next-state
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        cnt_d = cnt_q;
        if (w_launch) begin
            pc_d  = 8'h00;
            cnt_d = 16'h0000;
        end else if (state_q == S_FETCH) begin
            ir_d = instr;
        end else if (w_retire) begin
            pc_d  = (w_is_cmp && to_jump) ? jump_target : pc_q + 8'd1;
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            pc_q  <= 8'h00;
            ir_q  <= 9'h000;
            cnt_q <= 16'h0000;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            cnt_q <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign ir          = ir_q;
    assign op          = ir_q[7:4];
    assign reg_addr    = ir_q[3:0];
    assign lut_idx     = ir_q[3:0];
    assign instr_count = cnt_q;

endmodule

`default_nettype wire
